fc_input_deserializer: RTL and testbench

//  Serial-to-parallel collector; the receiving end of the serial word stream that fc_output_layer produces.

---
 rtl/fc_input_deserializer_if.sv | 37 +++
 rtl/fc_input_deserializer.sv | 129 ++++++++++++
 tb/tb_fc_input_deserializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fc_input_deserializer_if.sv
// Bus bundle for fc_input_deserializer: serial word input side and parallel frame output side.
// The class_o member exists only when FC_DESER_ARGMAX_EN is defined.
interface fc_input_deserializer_if #(
    parameter int unsigned LAYER_HEIGHT = 10,
    parameter int unsigned WORD_SIZE    = 16
);
    localparam int unsigned CLASS_W = $clog2(LAYER_HEIGHT);

    logic                                   clear_i;
    logic                                   valid_i;
    logic                                   ready_o;
    logic [WORD_SIZE-1:0]                   data_i;
    logic                                   valid_o;
    logic                                   yumi_i;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o;
`ifdef FC_DESER_ARGMAX_EN
    logic [CLASS_W-1:0]                     class_o;
`endif

    // Producer/consumer side
    modport master (
        output clear_i, valid_i, data_i, yumi_i,
`ifdef FC_DESER_ARGMAX_EN
        input  class_o,
`endif
        input  ready_o, valid_o, data_o
    );

    // Deserializer side
    modport slave (
        input  clear_i, valid_i, data_i, yumi_i,
`ifdef FC_DESER_ARGMAX_EN
        output class_o,
`endif
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/fc_input_deserializer.sv
// Serial-to-parallel frame collector: gathers LAYER_HEIGHT words (valid/ready in)
// and presents them as one packed frame (valid/yumi out).
// Optional argmax tracker over the frame enabled by defining FC_DESER_ARGMAX_EN.
module fc_input_deserializer #(
    parameter int unsigned LAYER_HEIGHT = 10,
    parameter int unsigned WORD_SIZE    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    fc_input_deserializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(LAYER_HEIGHT);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e                                 state_q;
    state_e                                 state_d;
    logic                                   ready_q;
    logic                                   ready_d;
    logic                                   valid_q;
    logic                                   valid_d;
    logic [CNT_W-1:0]                       count_q;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_q;
    logic                                   clear_c;
    logic                                   accept_c;
    logic                                   last_c;

    // ready_q is only ever high in FILL, so it qualifies the input handshake alone
    assign clear_c  = bus.clear_i && (state_q == S_FILL);
    assign accept_c = bus.valid_i && ready_q && !bus.clear_i;
    assign last_c   = (count_q == CNT_W'(LAYER_HEIGHT - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_FILL;
        else            state_q <= state_d;
    end

    // Next-state: fill until the last word lands, hold until the consumer takes the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: if (accept_c && last_c) state_d = S_FULL;
            S_FULL: if (bus.yumi_i)         state_d = S_FILL;
            default:                        state_d = S_FILL;
        endcase
    end

    // Output decode from the upcoming state so the handshake flags register in step with it
    always_comb begin
        ready_d = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            S_FILL:  ready_d = 1'b1;
            S_FULL:  valid_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    // Registered handshake outputs; ready stays low for the first cycle out of reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Word slot counter; clear restarts the frame, wraps to 0 on the last word
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    count_q <= '0;
        else if (clear_c)  count_q <= '0;
        else if (accept_c) count_q <= last_c ? '0 : count_q + CNT_W'(1);
    end

    // Frame storage; old contents survive a clear and are overwritten slot by slot
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    data_q          <= '0;
        else if (accept_c) data_q[count_q] <= bus.data_i;
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;

`ifdef FC_DESER_ARGMAX_EN
    logic signed [WORD_SIZE-1:0] max_q;
    logic signed [WORD_SIZE-1:0] max_c;
    logic signed [WORD_SIZE-1:0] word_s;
    logic [CNT_W-1:0]            idx_q;
    logic [CNT_W-1:0]            idx_c;
    logic [CNT_W-1:0]            class_q;

    // Running max: word 0 seeds it, later words win only when strictly greater
    always_comb begin
        word_s = $signed(bus.data_i);
        max_c  = max_q;
        idx_c  = idx_q;
        if ((count_q == '0) || (word_s > max_q)) begin
            max_c = word_s;
            idx_c = count_q;
        end
    end

    // Tracker registers; class_q captures the winner as the frame completes
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            max_q   <= '0;
            idx_q   <= '0;
            class_q <= '0;
        end else if (clear_c) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (accept_c) begin
            max_q <= max_c;
            idx_q <= idx_c;
            if (last_c) class_q <= idx_c;
        end
    end

    assign bus.class_o = class_q;
`endif

endmodule

// File: tb/tb_fc_input_deserializer.sv
// Self-checking bench for fc_input_deserializer (LAYER_HEIGHT=10, WORD_SIZE=16).
// Argmax checks are compiled in when FC_DESER_ARGMAX_EN is defined.
module tb_fc_input_deserializer;
    localparam int unsigned LH = 10;
    localparam int unsigned WS = 16;
    localparam int unsigned CW = $clog2(LH);

    logic clk_i = 1'b0;
    logic reset_n_i;

    always #5 clk_i = ~clk_i;

    fc_input_deserializer_if #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) bus ();

    fc_input_deserializer #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words collected so far, last completed frame, handshake flags
    logic [WS-1:0] part[$];
    logic [WS-1:0] frame[$];
    bit            m_ready;
    bit            m_full;

    typedef struct {
        logic          clear;
        logic          valid;
        logic [WS-1:0] data;
        logic          yumi;
        logic          exp_ready;
        logic          exp_valid;
    } vec_t;

    vec_t tbl[13];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef FC_DESER_ARGMAX_EN
    // Index of the first occurrence of the largest signed word in the frame
    function automatic logic [CW-1:0] exp_class();
        int idx = 0;
        logic signed [WS-1:0] mx = $signed(frame[0]);
        for (int i = 1; i < int'(LH); i++) begin
            if ($signed(frame[i]) > mx) begin
                mx  = $signed(frame[i]);
                idx = i;
            end
        end
        return CW'(idx);
    endfunction
`endif

    task automatic check_frame(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < int'(LH); i++)
            if (bad < 0 && bus.data_o[i] !== frame[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: data_o[%0d] got 0x%0h expected 0x%0h at %0t",
                     name, bad, bus.data_o[bad], frame[bad], $time);
        end
`ifdef FC_DESER_ARGMAX_EN
        check_val({name, "_class"}, 32'(bus.class_o), 32'(exp_class()));
`endif
    endtask

    task automatic model_reset();
        part.delete();
        m_ready = 1'b0;
        m_full  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare
    task automatic run_cycle(input logic c, input logic v, input logic [WS-1:0] d, input logic y);
        bus.clear_i = c;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.yumi_i  = y;
        if (m_full) begin
            if (y) begin
                m_full  = 1'b0;
                m_ready = 1'b1;
            end
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (c) begin
            part.delete();
        end else if (v) begin
            part.push_back(d);
            if (part.size() == LH) begin
                frame   = part;
                part.delete();
                m_full  = 1'b1;
                m_ready = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        check_val("ready_o", 32'(bus.ready_o), 32'(m_ready));
        check_val("valid_o", 32'(bus.valid_o), 32'(m_full));
        if (m_full) check_frame("frame");
    endtask

    int       sent;
    int       frames;
    int       bubbles;
    int       cyc;
    logic     y6;
    logic     v6;
    bit       acc6;
    logic [WS-1:0] argw[LH];

    initial begin
        bus.clear_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.yumi_i  = 1'b0;
        reset_n_i   = 1'b1;
        #1 reset_n_i = 1'b0;
        #10;
        check_val("reset_ready", 32'(bus.ready_o), 0);
        check_val("reset_valid", 32'(bus.valid_o), 0);
        check_val("reset_data", 32'(|bus.data_o), 0);
        #11 reset_n_i = 1'b1;

        // Test 1 table: first edge out of reset only raises ready, then 10 words
        tbl[0] = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 9; i++)
            tbl[i] = '{1'b0, 1'b1, 16'(i), 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            bus.clear_i = tbl[i].clear;
            bus.valid_i = tbl[i].valid;
            bus.data_i  = tbl[i].data;
            bus.yumi_i  = tbl[i].yumi;
            @(posedge clk_i);
            #1;
            check_val($sformatf("tbl%0d_ready", i), 32'(bus.ready_o), 32'(tbl[i].exp_ready));
            check_val($sformatf("tbl%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].exp_valid));
        end
        for (int i = 0; i < int'(LH); i++)
            check_val($sformatf("t1_data%0d", i), 32'(bus.data_o[i]), 32'(i + 1));

        part.delete();
        m_ready = 1'b1;
        m_full  = 1'b0;

        // Test 2: hold a frame for 20 cycles with valid_i toggling, then release
        for (int i = 0; i < int'(LH); i++) run_cycle(1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'(i % 2), 16'($urandom), 1'b0);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Test 3: clear after 4 words drops the same-cycle word
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 16'(16'h0AA0 + i), 1'b0);
        run_cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < int'(LH); i++) run_cycle(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
        check_val("t3_data0", 32'(bus.data_o[0]), 32'h0100);
        check_val("t3_data9", 32'(bus.data_o[9]), 32'h0109);
        run_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check_val("t3_clear_in_full", 32'(bus.valid_o), 1);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Test 4: asynchronous reset between edges after 6 words
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 16'(16'h0F00 + i), 1'b0);
        bus.valid_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check_val("t4_ready", 32'(bus.ready_o), 0);
        check_val("t4_valid", 32'(bus.valid_o), 0);
        check_val("t4_data", 32'(|bus.data_o), 0);
        check_val("t4_count", 32'(dut.count_q), 0);
        model_reset();
        @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        run_cycle(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < int'(LH); i++) run_cycle(1'b0, 1'b1, 16'(16'h0300 + i), 1'b0);
        check_val("t4_data0", 32'(bus.data_o[0]), 32'h0300);
        check_val("t4_data9", 32'(bus.data_o[9]), 32'h0309);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);

`ifdef FC_DESER_ARGMAX_EN
        // Test 5: negatives and a tie at indices 2/3
        argw = '{16'hFFF0, 16'h0200, 16'h0800, 16'h0800, 16'h8000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h07FF};
        for (int i = 0; i < int'(LH); i++) run_cycle(1'b0, 1'b1, argw[i], 1'b0);
        check_val("t5_class", 32'(bus.class_o), 2);
        run_cycle(1'b0, 1'b0, 16'h0, 1'b1);
`endif

        // Test 6: three back-to-back frames with yumi answering valid_o immediately
        sent    = 0;
        frames  = 0;
        bubbles = 0;
        cyc     = 0;
        while (frames < 3 && cyc < 100) begin
            y6   = m_full;
            v6   = (sent < 30);
            acc6 = m_ready && v6;
            run_cycle(1'b0, v6, 16'(16'h1000 + sent), y6);
            if (acc6) sent++;
            if (y6) frames++;
            if (!bus.ready_o) bubbles++;
            if (bus.valid_o)
                for (int i = 0; i < int'(LH); i++)
                    check_val("t6_order", 32'(bus.data_o[i]), 32'(16'h1000 + frames * 10 + i));
            cyc++;
        end
        check_val("t6_frames", 32'(frames), 3);
        check_val("t6_words", 32'(sent), 30);
        check_val("t6_bubbles", 32'(bubbles), 3);

        // Randomised traffic including clears and stray yumi
        for (int i = 0; i < 600; i++)
            run_cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7),
                      16'($urandom), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
